// File: rtl/div_seq_ctrl_if.sv
// Handshake/result bundle between the EX stage and the DIV/DIVU sequencer.
// master: pipeline side (issues requests, consumes results)
// slave : divider side
interface div_seq_ctrl_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;

   modport master (
      output start, signed_op, dividend, divisor, flush,
      input  busy, done, quotient, remainder
   );

   modport slave (
      input  start, signed_op, dividend, divisor, flush,
      output busy, done, quotient, remainder
   );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for a multi-cycle radix-2 restoring divider (DIV/DIVU).
// IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE; busy stalls EX, done pulses
// for one cycle with quotient (LO) and remainder (HI) valid.
// Optional feature: define DIV_EARLY_OUT_EN to skip ITER when the divisor
// magnitude exceeds the dividend magnitude or the divisor is zero.
module div_seq_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   div_seq_ctrl_if.slave     bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvs_q;
   logic             sgn_q;
   logic [WIDTH-1:0] quo_q, rem_q, b_q;
   logic [CW-1:0]    cnt_q;
   logic             neg_q_q, neg_r_q, dz_q;
   logic [WIDTH-1:0] q_out_q, r_out_q;

   logic             a_neg, b_neg, dvs_zero, early;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] quo_nx, rem_nx;
   logic             load_out;
   logic [WIDTH-1:0] fin_q_mag, fin_r_mag;
   logic             fin_dz, fin_nq, fin_nr;
   logic [WIDTH-1:0] fin_q, fin_r;

   // Magnitudes of the captured operands; -(2^(WIDTH-1)) maps to unsigned 2^(WIDTH-1).
   assign a_neg    = sgn_q & dvd_q[WIDTH-1];
   assign b_neg    = sgn_q & dvs_q[WIDTH-1];
   assign a_abs    = a_neg ? -dvd_q : dvd_q;
   assign b_abs    = b_neg ? -dvs_q : dvs_q;
   assign dvs_zero = (dvs_q == '0);

`ifdef DIV_EARLY_OUT_EN
   assign early = dvs_zero || (b_abs > a_abs);
`else
   assign early = 1'b0;
`endif

   // One restoring step: comparing the shifted remainder against the divisor is
   // the sign test of the WIDTH+1-bit difference; the kept remainder fits WIDTH bits.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign ge     = (rem_sh >= {1'b0, b_q});
   assign quo_nx = {quo_q[WIDTH-2:0], ge};
   assign rem_nx = ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];

   // Sign fix / divide-by-zero override applied to whichever magnitudes finish this cycle.
   assign fin_q = fin_dz ? '1    : (fin_nq ? -fin_q_mag : fin_q_mag);
   assign fin_r = fin_dz ? dvd_q : (fin_nr ? -fin_r_mag : fin_r_mag);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state, plus selection of the result that is written on entry to FIX.
   always_comb begin
      state_d   = state_q;
      load_out  = 1'b0;
      fin_q_mag = '0;
      fin_r_mag = '0;
      fin_dz    = 1'b0;
      fin_nq    = 1'b0;
      fin_nr    = 1'b0;
      case (state_q)
         IDLE: if (bus.start && !bus.flush) state_d = PREP;
         PREP: begin
            fin_r_mag = a_abs;
            fin_dz    = dvs_zero;
            fin_nq    = a_neg ^ b_neg;
            fin_nr    = a_neg;
            if (bus.flush) state_d = IDLE;
            else if (early) begin
               state_d  = FIX;
               load_out = 1'b1;
            end else state_d = ITER;
         end
         ITER: begin
            fin_q_mag = quo_nx;
            fin_r_mag = rem_nx;
            fin_dz    = dz_q;
            fin_nq    = neg_q_q;
            fin_nr    = neg_r_q;
            if (bus.flush) state_d = IDLE;
            else if (cnt_q == '0) begin
               state_d  = FIX;
               load_out = 1'b1;
            end
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand capture, magnitude prep, iteration and result registers.
   // Results are registered on entry to FIX so they are valid during the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         dvd_q   <= '0;
         dvs_q   <= '0;
         sgn_q   <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dz_q    <= 1'b0;
         q_out_q <= '0;
         r_out_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.start && !bus.flush) begin
               dvd_q <= bus.dividend;
               dvs_q <= bus.divisor;
               sgn_q <= bus.signed_op;
            end
            PREP: begin
               quo_q   <= a_abs;
               b_q     <= b_abs;
               rem_q   <= '0;
               cnt_q   <= CW'(WIDTH - 1);
               neg_q_q <= a_neg ^ b_neg;
               neg_r_q <= a_neg;
               dz_q    <= dvs_zero;
            end
            ITER: if (!bus.flush) begin
               quo_q <= quo_nx;
               rem_q <= rem_nx;
               cnt_q <= cnt_q - 1'b1;
            end
            default: ;
         endcase
         if (load_out) begin
            q_out_q <= fin_q;
            r_out_q <= fin_r;
         end
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == FIX);
   assign bus.quotient  = q_out_q;
   assign bus.remainder = r_out_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized self-checking bench for div_seq_ctrl against an arithmetic model.
// Honours DIV_EARLY_OUT_EN for the expected latency.
module tb_div_seq_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   div_seq_ctrl_if #(.WIDTH(32)) bus ();

   div_seq_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division; MIN/-1 wraps naturally via 64-bit arithmetic.
   task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   function automatic int ref_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint ma, mb;
      ma = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      mb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
      if (b == 0 || mb > ma) return 2;
`endif
      return 34;
   endfunction

   task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      bus.signed_op = sgn;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
   endtask

   // Issue one op (inputs set after a negedge), check latency, busy span, results.
   task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      int cyc, busy_cnt, lat;
      bit got;
      ref_div(sgn, a, b, eq, er);
      lat = ref_lat(sgn, a, b);
      start_op(sgn, a, b);
      cyc = 0; busy_cnt = 0; got = 0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.busy) busy_cnt++;
         if (bus.done) got = 1;
      end
      check_val("done_latency", 64'(cyc), 64'(lat));
      check_val("busy_cycles", 64'(busy_cnt), 64'(lat));
      check_val("quotient", 64'(bus.quotient), 64'(eq));
      check_val("remainder", 64'(bus.remainder), 64'(er));
      @(negedge clk);
      check_val("done_after", 64'(bus.done), 64'd0);
      check_val("busy_after", 64'(bus.busy), 64'd0);
      last_q = eq;
      last_r = er;
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus.done) n++;
      end
   endtask

   initial begin
      int n, cyc;
      logic [31:0] a, b, eq, er;
      bit sgn, got;

      bus.start = 1'b0; bus.flush = 1'b0; bus.signed_op = 1'b0;
      bus.dividend = '0; bus.divisor = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_done", 64'(bus.done), 64'd0);
      check_val("rst_q", 64'(bus.quotient), 64'd0);
      check_val("rst_r", 64'(bus.remainder), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed corner cases.
      run_op(1'b0, 32'd100, 32'd7);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b0, 32'h1234_5678, 32'd0);
      run_op(1'b1, 32'hFFFF_FFF0, 32'd0);
      run_op(1'b0, 32'd3, 32'd10);
      run_op(1'b1, 32'hFFFF_FFFD, 32'd10);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1);

      // Flush mid-operation: no done, results held.
      bus.flush = 1'b1;
      bus.signed_op = 1'b0; bus.dividend = 32'd1; bus.divisor = 32'd1; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check_val("flush_wins_start", 64'(bus.busy), 64'd0);
      start_op(1'b0, 32'd50, 32'd5);
      repeat (10) @(negedge clk);
      check_val("busy_before_flush", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check_val("busy_after_flush", 64'(bus.busy), 64'd0);
      count_dones(40, n);
      check_val("flush_no_done", 64'(n), 64'd0);
      check_val("flush_q_held", 64'(bus.quotient), 64'(last_q));
      check_val("flush_r_held", 64'(bus.remainder), 64'(last_r));
      run_op(1'b0, 32'd9, 32'd3);

      // start held high throughout busy: only the first request is taken.
      ref_div(1'b0, 32'd1000, 32'd3, eq, er);
      start_op(1'b0, 32'd1000, 32'd3);
      bus.start = 1'b1;
      cyc = 0; got = 0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         bus.dividend = $urandom;
         bus.divisor  = $urandom;
         if (bus.done) begin
            got = 1;
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check_val("stream_latency", 64'(cyc), 64'd34);
      check_val("stream_q", 64'(bus.quotient), 64'(eq));
      check_val("stream_r", 64'(bus.remainder), 64'(er));
      count_dones(40, n);
      check_val("stream_single_done", 64'(n), 64'd0);
      last_q = eq; last_r = er;

      // Reset in the middle of an operation.
      start_op(1'b0, 32'd1000, 32'd7);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_val("midrst_busy", 64'(bus.busy), 64'd0);
      check_val("midrst_done", 64'(bus.done), 64'd0);
      check_val("midrst_q", 64'(bus.quotient), 64'd0);
      check_val("midrst_r", 64'(bus.remainder), 64'd0);
      count_dones(40, n);
      check_val("midrst_no_done", 64'(n), 64'd0);

      // Randomized operations with biased operand choice.
      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       a = 32'h8000_0000;
            1:       a = 32'($urandom_range(0, 50));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2, 3:    b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         run_op(sgn, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
